// File: rtl/router_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// router_port_arbiter_if
//
// Purpose:
//   Bundles the beat handshakes around the router port arbiter: the two input
//   ports (A and B) and the per-output-port slot interface.
//
// Signals:
//   a_valid/a_ready/a_data/a_addr  input port A beat handshake
//   b_valid/b_ready/b_data/b_addr  input port B beat handshake
//   out_valid[NUM_OUT]             per-output-port beat held
//   out_ready[NUM_OUT]             per-output-port beat taken by the buffer
//   out_data[NUM_OUT*DATA_W]       port p at [p*DATA_W +: DATA_W]
//   out_src[NUM_OUT]               source of the held beat (0=A, 1=B)
//
// Modports:
//   slave  - the arbiter itself
//   master - the surrounding port drivers / output buffers
// ---------------------------------------------------------------------------
interface router_port_arbiter_if #(
    parameter int NUM_OUT = 4,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8
);
    logic                      a_valid;
    logic                      a_ready;
    logic [DATA_W-1:0]         a_data;
    logic [ADDR_W-1:0]         a_addr;
    logic                      b_valid;
    logic                      b_ready;
    logic [DATA_W-1:0]         b_data;
    logic [ADDR_W-1:0]         b_addr;
    logic [NUM_OUT-1:0]        out_valid;
    logic [NUM_OUT-1:0]        out_ready;
    logic [NUM_OUT*DATA_W-1:0] out_data;
    logic [NUM_OUT-1:0]        out_src;

    modport slave (
        input  a_valid, a_data, a_addr,
        input  b_valid, b_data, b_addr,
        input  out_ready,
        output a_ready, b_ready,
        output out_valid, out_data, out_src
    );

    modport master (
        output a_valid, a_data, a_addr,
        output b_valid, b_data, b_addr,
        output out_ready,
        input  a_ready, b_ready,
        input  out_valid, out_data, out_src
    );
endinterface

// File: rtl/router_port_arbiter.sv
// ---------------------------------------------------------------------------
// router_port_arbiter
//
// Purpose:
//   Shares NUM_OUT output ports between two input ports (A, B). Each beat is
//   steered by addr[$clog2(NUM_OUT)-1:0] into a one-entry slot per output
//   port. Contention for a port is resolved per port by round-robin or fixed
//   priority; beats to disabled ports are accepted, dropped and counted.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ctrl_wr_en      control register write strobe
//   ctrl_wr_data    control write data
//   ctrl_q          control register value
//                     [0] enable, [1] rr_en, [2] fixed_sel,
//                     [15:8] port_mask, [31] clr_drop (pulse, reads 0)
//   bus             beat handshakes (router_port_arbiter_if.slave)
//   drop_cnt        saturating count of dropped beats
// ---------------------------------------------------------------------------
module router_port_arbiter #(
    parameter int NUM_OUT = 4,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ctrl_wr_en,
    input  logic [31:0]          ctrl_wr_data,
    output logic [31:0]          ctrl_q,
    router_port_arbiter_if.slave bus,
    output logic [15:0]          drop_cnt
);

    localparam int DW   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam int NDST = 1 << DW;

    localparam logic [31:0] CTRL_RST   = 32'h0000_FF03;
    // Only enable, rr_en, fixed_sel and port_mask are held; the rest read 0.
    localparam logic [31:0] CTRL_STORE = 32'h0000_FF07;

    logic [31:0]               r_ctrl;
    logic [NUM_OUT-1:0]        r_valid;
    logic [NUM_OUT-1:0]        r_src;
    logic [NUM_OUT-1:0]        r_rr_last;   // last granted source per port (0=A, 1=B)
    logic [NUM_OUT*DATA_W-1:0] r_data;
    logic [15:0]               r_drop_cnt;

    logic            w_enable;
    logic            w_rr_en;
    logic            w_fixed_sel;
    logic [DW-1:0]   w_a_dst;
    logic [DW-1:0]   w_b_dst;
    logic [NDST-1:0] w_port_en_ext;
    logic [NDST-1:0] w_free_ext;
    logic            w_a_en;
    logic            w_b_en;
    logic            w_contend;
    logic            w_a_wins;
    logic            w_a_ready;
    logic            w_b_ready;
    logic            w_a_grant;
    logic            w_b_grant;
    logic            w_a_drop;
    logic            w_b_drop;
    logic [NUM_OUT-1:0] w_a_load;
    logic [NUM_OUT-1:0] w_b_load;
    logic [1:0]      w_drop_inc;
    logic [16:0]     w_drop_sum;
    logic            w_clr_drop;
    logic            w_unused_bits;

    assign w_enable    = r_ctrl[0];
    assign w_rr_en     = r_ctrl[1];
    assign w_fixed_sel = r_ctrl[2];
    assign w_a_dst     = bus.a_addr[DW-1:0];
    assign w_b_dst     = bus.b_addr[DW-1:0];
    assign w_clr_drop  = ctrl_wr_en & ctrl_wr_data[31];

    // Enable/free vectors are widened to the full destination code space so
    // codes >= NUM_OUT (non-power-of-two NUM_OUT) read as disabled ports.
    always_comb begin
        w_port_en_ext = '0;
        w_free_ext    = '0;
        w_port_en_ext[NUM_OUT-1:0] = r_ctrl[8 +: NUM_OUT];
        w_free_ext[NUM_OUT-1:0]    = ~r_valid | bus.out_ready;
    end

    assign w_a_en    = w_port_en_ext[w_a_dst];
    assign w_b_en    = w_port_en_ext[w_b_dst];
    assign w_contend = bus.a_valid & bus.b_valid & w_a_en & w_b_en & (w_a_dst == w_b_dst);
    // Round-robin: A wins unless A was the last source granted to this port.
    assign w_a_wins  = w_rr_en ? r_rr_last[w_a_dst] : ~w_fixed_sel;

    always_comb begin
        w_a_ready = 1'b0;
        w_b_ready = 1'b0;
        w_a_grant = 1'b0;
        w_b_grant = 1'b0;
        w_a_drop  = 1'b0;
        w_b_drop  = 1'b0;
        if (!rst && w_enable) begin
            if (bus.a_valid) begin
                if (!w_a_en) begin
                    w_a_ready = 1'b1;
                    w_a_drop  = 1'b1;
                end else if (w_free_ext[w_a_dst] && (!w_contend || w_a_wins)) begin
                    w_a_ready = 1'b1;
                    w_a_grant = 1'b1;
                end
            end
            if (bus.b_valid) begin
                if (!w_b_en) begin
                    w_b_ready = 1'b1;
                    w_b_drop  = 1'b1;
                end else if (w_free_ext[w_b_dst] && (!w_contend || !w_a_wins)) begin
                    w_b_ready = 1'b1;
                    w_b_grant = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_OUT; p++) begin
            w_a_load[p] = w_a_grant && (w_a_dst == DW'(p));
            w_b_load[p] = w_b_grant && (w_b_dst == DW'(p));
        end
    end

    // Output slots: a load wins over a drain, which gives drain-and-fill in
    // one cycle. A and B never load the same port in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= '0;
            r_src     <= '0;
            r_data    <= '0;
            r_rr_last <= '1;
        end else begin
            for (int p = 0; p < NUM_OUT; p++) begin
                if (w_a_load[p]) begin
                    r_valid[p]                   <= 1'b1;
                    r_src[p]                     <= 1'b0;
                    r_data[p*DATA_W +: DATA_W]   <= bus.a_data;
                    r_rr_last[p]                 <= 1'b0;
                end else if (w_b_load[p]) begin
                    r_valid[p]                   <= 1'b1;
                    r_src[p]                     <= 1'b1;
                    r_data[p*DATA_W +: DATA_W]   <= bus.b_data;
                    r_rr_last[p]                 <= 1'b1;
                end else if (bus.out_ready[p]) begin
                    r_valid[p]                   <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl <= CTRL_RST;
        end else if (ctrl_wr_en) begin
            r_ctrl <= ctrl_wr_data & CTRL_STORE;
        end
    end

    assign w_drop_inc = {1'b0, w_a_drop} + {1'b0, w_b_drop};
    assign w_drop_sum = {1'b0, r_drop_cnt} + {15'd0, w_drop_inc};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_clr_drop) begin
            r_drop_cnt <= '0;
        end else if (w_drop_sum[16]) begin
            r_drop_cnt <= 16'hFFFF;
        end else begin
            r_drop_cnt <= w_drop_sum[15:0];
        end
    end

    assign ctrl_q        = r_ctrl;
    assign drop_cnt      = r_drop_cnt;
    assign bus.a_ready   = w_a_ready;
    assign bus.b_ready   = w_b_ready;
    assign bus.out_valid = r_valid;
    assign bus.out_data  = r_data;
    assign bus.out_src   = r_src;

    // Address bits above the destination field and control bits outside the
    // decoded fields carry no meaning here.
    assign w_unused_bits = ^{bus.a_addr[ADDR_W-1:DW], bus.b_addr[ADDR_W-1:DW],
                             r_ctrl[31:3], w_port_en_ext};

endmodule

// File: tb/tb_router_port_arbiter.sv
module tb_router_port_arbiter;

    localparam int NUM_OUT = 4;
    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 8;

    logic        clk;
    logic        rst;
    logic        ctrl_wr_en;
    logic [31:0] ctrl_wr_data;
    logic [31:0] ctrl_q;
    logic [15:0] drop_cnt;

    int total = 0;
    int bad   = 0;

    router_port_arbiter_if #(.NUM_OUT(NUM_OUT), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    router_port_arbiter #(.NUM_OUT(NUM_OUT), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .ctrl_wr_en   (ctrl_wr_en),
        .ctrl_wr_data (ctrl_wr_data),
        .ctrl_q       (ctrl_q),
        .bus          (bus.slave),
        .drop_cnt     (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_ctrl(input logic [31:0] val);
        ctrl_wr_en   = 1'b1;
        ctrl_wr_data = val;
        tick();
        ctrl_wr_en   = 1'b0;
        ctrl_wr_data = 32'h0;
    endtask

    initial begin
        rst           = 1'b1;
        ctrl_wr_en    = 1'b0;
        ctrl_wr_data  = 32'h0;
        bus.a_valid   = 1'b0;
        bus.a_data    = '0;
        bus.a_addr    = '0;
        bus.b_valid   = 1'b0;
        bus.b_data    = '0;
        bus.b_addr    = '0;
        bus.out_ready = '0;
        tick();
        tick();

        // Reset state
        chk("rst_ctrl_q", ctrl_q, 32'h0000FF03);
        chk("rst_out_valid", {28'd0, bus.out_valid}, 32'h0);
        chk("rst_out_data", bus.out_data, 32'h0);
        chk("rst_out_src", {28'd0, bus.out_src}, 32'h0);
        chk("rst_drop_cnt", {16'd0, drop_cnt}, 32'h0);
        bus.a_valid = 1'b1;
        bus.a_addr  = 8'h02;
        #1;
        chk("rst_a_ready", {31'd0, bus.a_ready}, 32'h0);
        bus.a_valid = 1'b0;
        rst = 1'b0;
        tick();

        // Single beat, held under backpressure
        bus.a_valid = 1'b1;
        bus.a_data  = 8'h5A;
        bus.a_addr  = 8'h02;
        #1;
        chk("single_a_ready", {31'd0, bus.a_ready}, 32'h1);
        tick();
        bus.a_valid = 1'b0;
        #1;
        chk("single_out_valid", {28'd0, bus.out_valid}, 32'h4);
        chk("single_out_data", {24'd0, bus.out_data[23:16]}, 32'h5A);
        chk("single_out_src", {31'd0, bus.out_src[2]}, 32'h0);
        tick();
        chk("single_hold_valid", {28'd0, bus.out_valid}, 32'h4);
        chk("single_hold_data", {24'd0, bus.out_data[23:16]}, 32'h5A);
        bus.out_ready = 4'b0100;
        tick();
        bus.out_ready = 4'b0000;
        chk("single_drained", {28'd0, bus.out_valid}, 32'h0);

        // Round-robin contention on port 1
        bus.out_ready = 4'hF;
        bus.a_valid = 1'b1; bus.a_data = 8'hA1; bus.a_addr = 8'h01;
        bus.b_valid = 1'b1; bus.b_data = 8'hB1; bus.b_addr = 8'h01;
        #1;
        chk("rr1_a_ready", {31'd0, bus.a_ready}, 32'h1);
        chk("rr1_b_ready", {31'd0, bus.b_ready}, 32'h0);
        tick();
        chk("rr1_out_data", {24'd0, bus.out_data[15:8]}, 32'hA1);
        chk("rr1_out_src", {31'd0, bus.out_src[1]}, 32'h0);
        bus.a_data = 8'hA2;
        #1;
        chk("rr2_a_ready", {31'd0, bus.a_ready}, 32'h0);
        chk("rr2_b_ready", {31'd0, bus.b_ready}, 32'h1);
        tick();
        chk("rr2_out_data", {24'd0, bus.out_data[15:8]}, 32'hB1);
        chk("rr2_out_src", {31'd0, bus.out_src[1]}, 32'h1);
        bus.b_data = 8'hB2;
        #1;
        chk("rr3_a_ready", {31'd0, bus.a_ready}, 32'h1);
        chk("rr3_b_ready", {31'd0, bus.b_ready}, 32'h0);
        tick();
        chk("rr3_out_data", {24'd0, bus.out_data[15:8]}, 32'hA2);
        chk("rr3_out_src", {31'd0, bus.out_src[1]}, 32'h0);
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        tick();
        chk("rr_drained", {28'd0, bus.out_valid}, 32'h0);

        // Fixed priority, B selected, contention on port 3
        wr_ctrl(32'h0000FF05);
        chk("fix_ctrl_q", ctrl_q, 32'h0000FF05);
        bus.a_valid = 1'b1; bus.a_data = 8'hC1; bus.a_addr = 8'h03;
        bus.b_valid = 1'b1; bus.b_data = 8'hD1; bus.b_addr = 8'h03;
        #1;
        chk("fix1_a_ready", {31'd0, bus.a_ready}, 32'h0);
        chk("fix1_b_ready", {31'd0, bus.b_ready}, 32'h1);
        tick();
        chk("fix1_out_data", {24'd0, bus.out_data[31:24]}, 32'hD1);
        chk("fix1_out_src", {31'd0, bus.out_src[3]}, 32'h1);
        bus.b_data = 8'hD2;
        #1;
        chk("fix2_a_ready", {31'd0, bus.a_ready}, 32'h0);
        chk("fix2_b_ready", {31'd0, bus.b_ready}, 32'h1);
        tick();
        chk("fix2_out_data", {24'd0, bus.out_data[31:24]}, 32'hD2);
        bus.b_valid = 1'b0;
        #1;
        chk("fix3_a_ready", {31'd0, bus.a_ready}, 32'h1);
        tick();
        chk("fix3_out_data", {24'd0, bus.out_data[31:24]}, 32'hC1);
        chk("fix3_out_src", {31'd0, bus.out_src[3]}, 32'h0);
        bus.a_valid = 1'b0;
        tick();

        // Masked port: both inputs dropped in one cycle, then clear
        wr_ctrl(32'h0000FB03);
        chk("mask_ctrl_q", ctrl_q, 32'h0000FB03);
        bus.a_valid = 1'b1; bus.a_data = 8'h11; bus.a_addr = 8'h02;
        bus.b_valid = 1'b1; bus.b_data = 8'h22; bus.b_addr = 8'h02;
        #1;
        chk("mask_a_ready", {31'd0, bus.a_ready}, 32'h1);
        chk("mask_b_ready", {31'd0, bus.b_ready}, 32'h1);
        tick();
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        #1;
        chk("mask_no_out", {28'd0, bus.out_valid}, 32'h0);
        chk("mask_drop_cnt", {16'd0, drop_cnt}, 32'h2);
        // A drop coincides with the clear; the clear wins.
        bus.a_valid = 1'b1;
        ctrl_wr_en   = 1'b1;
        ctrl_wr_data = 32'h8000FB03;
        #1;
        chk("clr_a_ready", {31'd0, bus.a_ready}, 32'h1);
        tick();
        ctrl_wr_en   = 1'b0;
        bus.a_valid  = 1'b0;
        chk("clr_drop_cnt", {16'd0, drop_cnt}, 32'h0);
        chk("clr_ctrl_q", ctrl_q, 32'h0000FB03);

        // Backpressure then streaming on port 0
        wr_ctrl(32'h0000FF03);
        bus.out_ready = 4'b0000;
        bus.a_valid = 1'b1; bus.a_data = 8'h01; bus.a_addr = 8'h00;
        #1;
        chk("bp1_a_ready", {31'd0, bus.a_ready}, 32'h1);
        tick();
        bus.a_data = 8'h02;
        #1;
        chk("bp2_a_ready", {31'd0, bus.a_ready}, 32'h0);
        tick();
        chk("bp_hold_valid", {28'd0, bus.out_valid}, 32'h1);
        chk("bp_hold_data", {24'd0, bus.out_data[7:0]}, 32'h01);
        bus.out_ready = 4'b0001;
        #1;
        chk("bp3_a_ready", {31'd0, bus.a_ready}, 32'h1);
        tick();
        chk("st1_out_data", {24'd0, bus.out_data[7:0]}, 32'h02);
        bus.a_data = 8'h03;
        #1;
        chk("st2_a_ready", {31'd0, bus.a_ready}, 32'h1);
        tick();
        chk("st2_out_data", {24'd0, bus.out_data[7:0]}, 32'h03);
        bus.a_data = 8'h04;
        #1;
        chk("st3_a_ready", {31'd0, bus.a_ready}, 32'h1);
        tick();
        chk("st3_out_data", {24'd0, bus.out_data[7:0]}, 32'h04);
        chk("st3_out_valid", {28'd0, bus.out_valid}, 32'h1);
        bus.a_valid = 1'b0;
        tick();
        chk("st_drained", {28'd0, bus.out_valid}, 32'h0);

        // Disable with held slots
        bus.out_ready = 4'b0000;
        bus.a_valid = 1'b1; bus.a_data = 8'h55; bus.a_addr = 8'h00;
        bus.b_valid = 1'b1; bus.b_data = 8'h66; bus.b_addr = 8'h01;
        #1;
        chk("par_a_ready", {31'd0, bus.a_ready}, 32'h1);
        chk("par_b_ready", {31'd0, bus.b_ready}, 32'h1);
        tick();
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        wr_ctrl(32'h0000FF02);
        chk("dis_ctrl_q", ctrl_q, 32'h0000FF02);
        chk("dis_held", {28'd0, bus.out_valid}, 32'h3);
        chk("dis_data", {16'd0, bus.out_data[15:0]}, 32'h6655);
        bus.a_valid = 1'b1; bus.a_addr = 8'h02;
        bus.b_valid = 1'b1; bus.b_addr = 8'h03;
        #1;
        chk("dis_a_ready", {31'd0, bus.a_ready}, 32'h0);
        chk("dis_b_ready", {31'd0, bus.b_ready}, 32'h0);
        bus.out_ready = 4'hF;
        tick();
        chk("dis_drained", {28'd0, bus.out_valid}, 32'h0);
        chk("dis_drop_cnt", {16'd0, drop_cnt}, 32'h0);
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;

        // Reserved bits, then reset with a beat held
        wr_ctrl(32'h7FFFFFFF);
        chk("resv_ctrl_q", ctrl_q, 32'h0000FF07);
        bus.out_ready = 4'b0000;
        bus.a_valid = 1'b1; bus.a_data = 8'h77; bus.a_addr = 8'h01;
        #1;
        chk("pre_rst_a_ready", {31'd0, bus.a_ready}, 32'h1);
        tick();
        chk("pre_rst_held", {28'd0, bus.out_valid}, 32'h2);
        chk("pre_rst_data", {24'd0, bus.out_data[15:8]}, 32'h77);
        bus.a_addr = 8'h00;
        rst = 1'b1;
        #1;
        chk("in_rst_a_ready", {31'd0, bus.a_ready}, 32'h0);
        tick();
        chk("post_rst_valid", {28'd0, bus.out_valid}, 32'h0);
        chk("post_rst_ctrl_q", ctrl_q, 32'h0000FF03);
        chk("post_rst_data", bus.out_data, 32'h0);
        rst = 1'b0;
        bus.a_valid = 1'b0;
        bus.out_ready = 4'hF;
        tick();
        chk("post_rst_no_beat", {28'd0, bus.out_valid}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
